// File: rtl/gcd_rr_sched.sv
// Round-robin arbiter sharing one iterative GCD unit among NREQS val/rdy clients.
// Optional per-client grant counters and busy-cycle counter: define GCD_RR_SCHED_STATS_EN.
//
// state | meaning
// IDLE  | arbitrating; forwards the granted request to the GCD unit
// WAIT  | one transaction outstanding; routes the result back to owner
module gcd_rr_sched #(
  parameter int NREQS = 4
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [NREQS-1:0]      req_val,
  output logic [NREQS-1:0]      req_rdy,
  input  logic [NREQS*32-1:0]   req_msg,
  output logic [NREQS-1:0]      resp_val,
  input  logic [NREQS-1:0]      resp_rdy,
  output logic [15:0]           resp_msg,
  output logic                  gcd_istream_val,
  input  logic                  gcd_istream_rdy,
  output logic [31:0]           gcd_istream_msg,
  input  logic                  gcd_ostream_val,
  output logic                  gcd_ostream_rdy,
  input  logic [15:0]           gcd_ostream_msg
`ifdef GCD_RR_SCHED_STATS_EN
  ,
  output logic [NREQS*16-1:0]   stat_grants,
  output logic [31:0]           stat_busy
`endif
);

  localparam int PW = (NREQS > 1) ? $clog2(NREQS) : 1;

  typedef enum logic {IDLE, WAIT} state_t;

  state_t        state;
  logic [PW-1:0] owner;
  logic [PW-1:0] prio_ptr;
  logic [PW-1:0] grant;
  logic [PW-1:0] next_ptr;
  logic          any_req;
  logic          req_fire;
  logic          resp_fire;

  // Scan from prio_ptr upward, wrapping modulo NREQS; first valid requester wins.
  always_comb begin
    logic [PW:0]   idx;
    logic [PW-1:0] idx_n;
    logic          found;
    grant = '0;
    found = 1'b0;
    idx   = '0;
    idx_n = '0;
    for (int k = 0; k < NREQS; k++) begin
      idx = {1'b0, prio_ptr} + (PW+1)'(k);
      if (idx >= (PW+1)'(NREQS))
        idx = idx - (PW+1)'(NREQS);
      idx_n = idx[PW-1:0];
      if (!found && req_val[idx_n]) begin
        grant = idx_n;
        found = 1'b1;
      end
    end
  end

  assign any_req = |req_val;

  always_comb begin
    req_rdy         = '0;
    resp_val        = '0;
    gcd_istream_val = 1'b0;
    gcd_ostream_rdy = 1'b0;
    gcd_istream_msg = any_req ? req_msg[grant*32 +: 32] : 32'h0;
    resp_msg        = gcd_ostream_msg;
    if (!reset) begin
      if (state == IDLE) begin
        gcd_istream_val = any_req;
        if (any_req)
          req_rdy[grant] = gcd_istream_rdy;
      end else begin
        resp_val[owner] = gcd_ostream_val;
        gcd_ostream_rdy = resp_rdy[owner];
      end
    end
  end

  assign req_fire  = gcd_istream_val && gcd_istream_rdy;
  assign resp_fire = gcd_ostream_val && gcd_ostream_rdy;
  assign next_ptr  = (owner == PW'(NREQS-1)) ? '0 : owner + 1'b1;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state    <= IDLE;
      owner    <= '0;
      prio_ptr <= '0;
    end else begin
      case (state)
        IDLE: if (req_fire) begin
          owner <= grant;
          state <= WAIT;
        end
        WAIT: if (resp_fire) begin
          prio_ptr <= next_ptr;
          state    <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

`ifdef GCD_RR_SCHED_STATS_EN
  // Grant counters saturate; the busy counter is allowed to wrap.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      stat_grants <= '0;
      stat_busy   <= '0;
    end else begin
      for (int i = 0; i < NREQS; i++) begin
        if (req_fire && (grant == PW'(i)) && (stat_grants[16*i +: 16] != 16'hFFFF))
          stat_grants[16*i +: 16] <= stat_grants[16*i +: 16] + 16'd1;
      end
      if (state == WAIT)
        stat_busy <= stat_busy + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_gcd_rr_sched.sv
// Directed self-checking bench for gcd_rr_sched; the bench plays the GCD unit.
module tb_gcd_rr_sched;
  localparam int NREQS = 4;

  logic                clk = 1'b0;
  logic                reset;
  logic [NREQS-1:0]    req_val;
  logic [NREQS-1:0]    req_rdy;
  logic [NREQS*32-1:0] req_msg;
  logic [NREQS-1:0]    resp_val;
  logic [NREQS-1:0]    resp_rdy;
  logic [15:0]         resp_msg;
  logic                gcd_istream_val;
  logic                gcd_istream_rdy;
  logic [31:0]         gcd_istream_msg;
  logic                gcd_ostream_val;
  logic                gcd_ostream_rdy;
  logic [15:0]         gcd_ostream_msg;
`ifdef GCD_RR_SCHED_STATS_EN
  logic [NREQS*16-1:0] stat_grants;
  logic [31:0]         stat_busy;
`endif

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  gcd_rr_sched #(.NREQS(NREQS)) dut (
    .clk             (clk),
    .reset           (reset),
    .req_val         (req_val),
    .req_rdy         (req_rdy),
    .req_msg         (req_msg),
    .resp_val        (resp_val),
    .resp_rdy        (resp_rdy),
    .resp_msg        (resp_msg),
    .gcd_istream_val (gcd_istream_val),
    .gcd_istream_rdy (gcd_istream_rdy),
    .gcd_istream_msg (gcd_istream_msg),
    .gcd_ostream_val (gcd_ostream_val),
    .gcd_ostream_rdy (gcd_ostream_rdy),
    .gcd_ostream_msg (gcd_ostream_msg)
`ifdef GCD_RR_SCHED_STATS_EN
    ,
    .stat_grants     (stat_grants),
    .stat_busy       (stat_busy)
`endif
  );

  task automatic apply_reset();
    @(negedge clk);
    reset = 1'b1;
    req_val = '0;
    gcd_ostream_val = 1'b0;
    @(negedge clk);
    reset = 1'b0;
  endtask

  // Drives one full transaction for a lone requester; result returned after delay extra cycles.
  task automatic serve(input int idx, input logic [31:0] msg, input logic [15:0] res, input int delay);
    @(negedge clk);
    req_msg[32*idx +: 32] = msg;
    req_val = NREQS'(1) << idx;
    gcd_istream_rdy = 1'b1;
    resp_rdy = '1;
    @(negedge clk);
    req_val = '0;
    repeat (delay) @(negedge clk);
    gcd_ostream_val = 1'b1;
    gcd_ostream_msg = res;
    @(negedge clk);
    gcd_ostream_val = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    req_val = '1;
    req_msg = '0;
    gcd_istream_rdy = 1'b1;
    gcd_ostream_val = 1'b1;
    gcd_ostream_msg = 16'h1234;
    resp_rdy = '1;
    #3;
    checks++; if (req_rdy !== 4'b0000) begin failures++; $display("FAIL reset_req_rdy got=%b exp=0000", req_rdy); end
    checks++; if (resp_val !== 4'b0000) begin failures++; $display("FAIL reset_resp_val got=%b exp=0000", resp_val); end
    checks++; if (gcd_istream_val !== 1'b0) begin failures++; $display("FAIL reset_istream_val got=%b exp=0", gcd_istream_val); end
    checks++; if (gcd_ostream_rdy !== 1'b0) begin failures++; $display("FAIL reset_ostream_rdy got=%b exp=0", gcd_ostream_rdy); end
    @(negedge clk);
    req_val = '0;
    gcd_ostream_val = 1'b0;
    reset = 1'b0;
  endtask

  task automatic test_single();
    @(negedge clk);
    req_msg[31:0] = 32'h000F0005;
    req_val = 4'b0001;
    gcd_istream_rdy = 1'b1;
    resp_rdy = '1;
    #1;
    checks++; if (gcd_istream_msg !== 32'h000F0005) begin failures++; $display("FAIL single_istream_msg got=%h exp=000f0005", gcd_istream_msg); end
    checks++; if (req_rdy !== 4'b0001) begin failures++; $display("FAIL single_req_rdy got=%b exp=0001", req_rdy); end
    @(negedge clk);
    req_val = '0;
    #1;
    checks++; if (gcd_istream_val !== 1'b0 || resp_val !== 4'b0000) begin failures++; $display("FAIL single_wait_idle got_ival=%b got_rval=%b exp=0/0000", gcd_istream_val, resp_val); end
    gcd_ostream_val = 1'b1;
    gcd_ostream_msg = 16'd5;
    #1;
    checks++; if (resp_val !== 4'b0001 || resp_msg !== 16'd5) begin failures++; $display("FAIL single_resp got_val=%b got_msg=%0d exp=0001/5", resp_val, resp_msg); end
    checks++; if (gcd_ostream_rdy !== 1'b1) begin failures++; $display("FAIL single_ostream_rdy got=%b exp=1", gcd_ostream_rdy); end
    @(negedge clk);
    gcd_ostream_val = 1'b0;
    req_msg = {32'h0004_0002, 32'h0003_0001, 32'h0002_0001, 32'h0001_0001};
    req_val = 4'b1111;
    #1;
    checks++; if (req_rdy !== 4'b0010 || gcd_istream_msg !== 32'h0002_0001) begin failures++; $display("FAIL single_next_ptr got_rdy=%b got_msg=%h exp=0010/00020001", req_rdy, gcd_istream_msg); end
    req_val = '0;
  endtask

  task automatic test_all_four();
    logic [31:0] msgs [4];
    logic [15:0] res  [4];
    msgs[0] = 32'h001B0009; msgs[1] = 32'h0008000C; msgs[2] = 32'h00070003; msgs[3] = 32'h00000006;
    res[0] = 16'd9; res[1] = 16'd4; res[2] = 16'd1; res[3] = 16'd6;
    apply_reset();
    @(negedge clk);
    for (int i = 0; i < 4; i++) req_msg[32*i +: 32] = msgs[i];
    req_val = 4'b1111;
    gcd_istream_rdy = 1'b1;
    resp_rdy = '1;
    for (int i = 0; i < 4; i++) begin
      #1;
      checks++; if (req_rdy !== (4'b0001 << i) || gcd_istream_msg !== msgs[i]) begin failures++; $display("FAIL all4_grant%0d got_rdy=%b got_msg=%h exp_msg=%h", i, req_rdy, gcd_istream_msg, msgs[i]); end
      @(negedge clk);
      req_val[i] = 1'b0;
      gcd_ostream_val = 1'b1;
      gcd_ostream_msg = res[i];
      #1;
      checks++; if (resp_val !== (4'b0001 << i) || resp_msg !== res[i]) begin failures++; $display("FAIL all4_resp%0d got_val=%b got_msg=%0d exp_msg=%0d", i, resp_val, resp_msg, res[i]); end
      @(negedge clk);
      gcd_ostream_val = 1'b0;
    end
  endtask

  task automatic test_wrap();
    serve(2, 32'h00040002, 16'd2, 0);
    @(negedge clk);
    req_msg[127:96] = 32'h00300012;
    req_msg[31:0]   = 32'h0023000E;
    req_val = 4'b1001;
    gcd_istream_rdy = 1'b1;
    resp_rdy = '1;
    #1;
    checks++; if (req_rdy !== 4'b1000 || gcd_istream_msg !== 32'h00300012) begin failures++; $display("FAIL wrap_first got_rdy=%b got_msg=%h exp=1000/00300012", req_rdy, gcd_istream_msg); end
    @(negedge clk);
    req_val = 4'b0001;
    gcd_ostream_val = 1'b1;
    gcd_ostream_msg = 16'd6;
    #1;
    checks++; if (resp_val !== 4'b1000 || resp_msg !== 16'd6) begin failures++; $display("FAIL wrap_resp3 got_val=%b got_msg=%0d exp=1000/6", resp_val, resp_msg); end
    @(negedge clk);
    gcd_ostream_val = 1'b0;
    #1;
    checks++; if (req_rdy !== 4'b0001 || gcd_istream_msg !== 32'h0023000E) begin failures++; $display("FAIL wrap_second got_rdy=%b got_msg=%h exp=0001/0023000e", req_rdy, gcd_istream_msg); end
    @(negedge clk);
    req_val = '0;
    gcd_ostream_val = 1'b1;
    gcd_ostream_msg = 16'd7;
    #1;
    checks++; if (resp_val !== 4'b0001 || resp_msg !== 16'd7) begin failures++; $display("FAIL wrap_resp0 got_val=%b got_msg=%0d exp=0001/7", resp_val, resp_msg); end
    @(negedge clk);
    gcd_ostream_val = 1'b0;
    req_val = 4'b1111;
    #1;
    checks++; if (req_rdy !== 4'b0010) begin failures++; $display("FAIL wrap_ptr got_rdy=%b exp=0010", req_rdy); end
    req_val = '0;
  endtask

  task automatic test_back_pressure();
    @(negedge clk);
    req_msg[95:64] = 32'h00120008;
    req_msg[63:32] = 32'h00090006;
    req_val = 4'b0100;
    gcd_istream_rdy = 1'b1;
    resp_rdy = '1;
    #1;
    checks++; if (req_rdy !== 4'b0100) begin failures++; $display("FAIL bp_grant got_rdy=%b exp=0100", req_rdy); end
    @(negedge clk);
    req_val = 4'b0010;
    resp_rdy = 4'b1011;
    gcd_ostream_val = 1'b1;
    gcd_ostream_msg = 16'd2;
    for (int c = 0; c < 10; c++) begin
      #1;
      checks++; if (gcd_ostream_rdy !== 1'b0 || req_rdy !== 4'b0000 || gcd_istream_val !== 1'b0 || resp_val !== 4'b0100) begin
        failures++; $display("FAIL bp_stall%0d got_ordy=%b got_rrdy=%b got_ival=%b got_rval=%b exp=0/0000/0/0100", c, gcd_ostream_rdy, req_rdy, gcd_istream_val, resp_val);
      end
      @(negedge clk);
    end
    resp_rdy = 4'b1111;
    #1;
    checks++; if (gcd_ostream_rdy !== 1'b1 || resp_msg !== 16'd2) begin failures++; $display("FAIL bp_release got_ordy=%b got_msg=%0d exp=1/2", gcd_ostream_rdy, resp_msg); end
    @(negedge clk);
    #1;
    checks++; if (req_rdy !== 4'b0010 || gcd_istream_msg !== 32'h00090006) begin failures++; $display("FAIL bp_next_grant got_rdy=%b got_msg=%h exp=0010/00090006", req_rdy, gcd_istream_msg); end
    checks++; if (gcd_ostream_rdy !== 1'b0 || resp_val !== 4'b0000) begin failures++; $display("FAIL idle_ostream_ignored got_ordy=%b got_rval=%b exp=0/0000", gcd_ostream_rdy, resp_val); end
    req_val = '0;
    gcd_ostream_val = 1'b0;
  endtask

  task automatic test_reset_mid();
    @(negedge clk);
    req_msg[31:0] = 32'h0015000E;
    req_val = 4'b0001;
    gcd_istream_rdy = 1'b1;
    resp_rdy = '1;
    #1;
    checks++; if (req_rdy !== 4'b0001) begin failures++; $display("FAIL rmid_grant got_rdy=%b exp=0001", req_rdy); end
    @(negedge clk);
    req_val = '0;
    resp_rdy = '0;
    gcd_ostream_val = 1'b1;
    gcd_ostream_msg = 16'd7;
    #1;
    checks++; if (resp_val !== 4'b0001) begin failures++; $display("FAIL rmid_wait got_val=%b exp=0001", resp_val); end
    #2;
    reset = 1'b1;
    req_val = 4'b0001;
    #1;
    checks++; if (resp_val !== 4'b0000 || gcd_ostream_rdy !== 1'b0 || req_rdy !== 4'b0000 || gcd_istream_val !== 1'b0) begin
      failures++; $display("FAIL rmid_async got_rval=%b got_ordy=%b got_rrdy=%b got_ival=%b exp=0000/0/0000/0", resp_val, gcd_ostream_rdy, req_rdy, gcd_istream_val);
    end
    @(negedge clk);
    reset = 1'b0;
    resp_rdy = '1;
    gcd_ostream_val = 1'b0;
    #1;
    checks++; if (req_rdy !== 4'b0001 || gcd_istream_msg !== 32'h0015000E) begin failures++; $display("FAIL rmid_fresh got_rdy=%b got_msg=%h exp=0001/0015000e", req_rdy, gcd_istream_msg); end
    @(negedge clk);
    req_val = '0;
    gcd_ostream_val = 1'b1;
    gcd_ostream_msg = 16'd7;
    #1;
    checks++; if (resp_val !== 4'b0001 || resp_msg !== 16'd7) begin failures++; $display("FAIL rmid_result got_val=%b got_msg=%0d exp=0001/7", resp_val, resp_msg); end
    @(negedge clk);
    gcd_ostream_val = 1'b0;
  endtask

`ifdef GCD_RR_SCHED_STATS_EN
  task automatic test_stats();
    int busy_exp;
    int delays [3];
    delays[0] = 0; delays[1] = 2; delays[2] = 5;
    busy_exp = 0;
    apply_reset();
    for (int t = 0; t < 3; t++) begin
      serve(1, 32'h000F0005, 16'd5, delays[t]);
      busy_exp += delays[t] + 1;
    end
    #1;
    checks++; if (stat_grants[31:16] !== 16'd3) begin failures++; $display("FAIL stats_grant1 got=%0d exp=3", stat_grants[31:16]); end
    checks++; if (stat_grants[15:0] !== 16'd0 || stat_grants[63:32] !== 32'd0) begin failures++; $display("FAIL stats_grant_others got=%h exp=0", {stat_grants[63:32], stat_grants[15:0]}); end
    checks++; if (stat_busy !== 32'(busy_exp)) begin failures++; $display("FAIL stats_busy got=%0d exp=%0d", stat_busy, busy_exp); end
  endtask
`endif

  initial begin
    reset = 1'b1;
    req_val = '0;
    req_msg = '0;
    resp_rdy = '0;
    gcd_istream_rdy = 1'b0;
    gcd_ostream_val = 1'b0;
    gcd_ostream_msg = '0;
    test_reset();
    test_single();
    test_all_four();
    test_wrap();
    test_back_pressure();
    test_reset_mid();
`ifdef GCD_RR_SCHED_STATS_EN
    test_stats();
`endif
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
